gpi_rx_cond: RTL and testbench
==============================

GPI_RX_COND -- requirements
Module: gpi_rx_cond

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on the pad input (legal range 2..4).
REQ-002 Parameter FLT_W, default 4, width of the glitch-filter length and counter.
REQ-003 CLK_I  input  1  core clock; all state updates on the rising edge.
REQ-004 RST_NI  input  1  synchronous, active-low reset, sampled on the rising edge of CLK_I.
REQ-005 DI_I  input  1  raw pad-receiver data, asynchronous to CLK_I.
REQ-006 EN_I  input  1  block enable; when low, state is frozen and no new events are captured.
REQ-007 FLT_LEN_I  input  FLT_W  number of consecutive stable samples required to accept a level change; 0 means bypass.
REQ-008 EDGE_SEL_I  input  2  event selection: 00 none, 01 rising, 10 falling, 11 both.
REQ-009 ACK_I  input  1  consumer acknowledge; clears the pending event.
REQ-010 DI_O  output  1  filtered, synchronized pad level.
REQ-011 EVT_O  output  1  event pending.
REQ-012 EVT_LVL_O  output  1  filtered level immediately after the captured edge.
REQ-013 OVF_O  output  1  sticky flag: a qualifying edge occurred while EVT_O was high.

Function
REQ-014 DI_I shall pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized sample (sync).
REQ-015 The filter FSM shall have two states, STABLE and QUALIFY, plus a FLT_W-bit counter cnt.
REQ-016 In STABLE, sync != DI_O with FLT_LEN_I != 0 -> go to QUALIFY, cnt = 1.
REQ-017 In QUALIFY, sync == DI_O -> return to STABLE, cnt = 0, DI_O unchanged (glitch rejected).
REQ-018 In QUALIFY, sync != DI_O with cnt == FLT_LEN_I -> toggle DI_O, return to STABLE, cnt = 0; otherwise cnt increments.
REQ-019 cnt shall saturate and never wrap; a FLT_LEN_I change mid-QUALIFY takes effect on the next compare.
REQ-020 With FLT_LEN_I == 0, DI_O shall follow sync with exactly one cycle of delay.
REQ-021 Total latency from a DI_I change to DI_O = SYNC_STAGES + FLT_LEN_I + 1 cycles (FLT_LEN_I > 0), or SYNC_STAGES + 1 (bypass).
REQ-022 A DI_O toggle is a qualifying edge when EDGE_SEL_I selects its direction; it is evaluated in the same cycle as the toggle.
REQ-023 On a qualifying edge with EVT_O low: EVT_O goes high on the next cycle, and EVT_LVL_O = the new DI_O.
REQ-024 On a qualifying edge with EVT_O high and ACK_I low: OVF_O goes high; EVT_LVL_O is not updated.
REQ-025 Same-cycle ACK_I and qualifying edge with EVT_O high: treated as clear-then-capture; EVT_O stays high, EVT_LVL_O updates, no overflow.
REQ-026 ACK_I with EVT_O high and no edge: EVT_O clears on the next cycle; OVF_O also clears on ACK_I.
REQ-027 ACK_I while EVT_O is low shall have no effect.
REQ-028 With EN_I low: the synchronizer keeps running; FSM, cnt and DI_O hold; no event is captured; ACK_I still clears EVT_O and OVF_O.

Reset
REQ-029 With RST_NI low at a clock edge: the sync chain, DI_O, EVT_O, EVT_LVL_O and OVF_O shall all be 0, cnt = 0, and the state = STABLE.
REQ-030 A reset asserted mid-QUALIFY or with an event pending shall discard all progress; no event is generated on release.
REQ-031 After reset release with DI_I high, DI_O shall rise after the REQ-021 latency, and that edge counts as a rising event.

Structure
REQ-032 The state enum (STABLE/QUALIFY) and the EDGE_SEL encoding constants shall live in shared package gpi_rx_pkg.
REQ-033 The synchronizer shall be the sub-module gpi_rx_sync, parameterized by SYNC_STAGES; filter and event logic stay in gpi_rx_cond.

Verification
REQ-034 FLT_LEN_I=3, EDGE_SEL_I=01, DI_I 0->1 held -> DI_O rises 6 cycles later (SYNC_STAGES=2), EVT_O=1, EVT_LVL_O=1.
REQ-035 FLT_LEN_I=3, DI_I high pulse of 2 cycles -> DI_O stays 0 and EVT_O stays 0.
REQ-036 EDGE_SEL_I=11, two accepted edges with no ACK_I -> EVT_O=1, OVF_O=1, EVT_LVL_O reflects the first edge; then ACK_I -> EVT_O=0 and OVF_O=0 on the next cycle.
REQ-037 ACK_I coincident with a new qualifying edge -> EVT_O stays 1, EVT_LVL_O updates, OVF_O=0.
REQ-038 RST_NI low during QUALIFY with cnt=2 -> all outputs 0; after release with DI_I=0, no event is generated.
REQ-039 FLT_LEN_I=0, EN_I toggled low during an edge -> DI_O holds while EN_I is low, updates 1 cycle after EN_I returns high.

Source files
------------

// File: rtl/gpi_rx_pkg.sv
// gpi_rx_pkg: shared types and constants for the GPI receive conditioner.
package gpi_rx_pkg;
    typedef enum logic {STABLE, QUALIFY} state_t;
    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;
endpackage

// File: rtl/gpi_rx_sync.sv
// gpi_rx_sync: multi-flop synchronizer bringing the async pad level into the core clock.
module gpi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_chain;
    always_ff @(posedge i_clk) begin
        r_chain <= !i_rst_n ? '0 : {r_chain[SYNC_STAGES-2:0], i_d};
    end
    assign o_q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/gpi_rx_cond.sv
// gpi_rx_cond: synchronizes, glitch-filters and edge-detects a pad input,
// holding one pending event with sticky overflow until acknowledged.
module gpi_rx_cond import gpi_rx_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FLT_W       = 4
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             DI_I,
    input  logic             EN_I,
    input  logic [FLT_W-1:0] FLT_LEN_I,
    input  logic [1:0]       EDGE_SEL_I,
    input  logic             ACK_I,
    output logic             DI_O,
    output logic             EVT_O,
    output logic             EVT_LVL_O,
    output logic             OVF_O
);
    logic             w_sync;
    state_t           r_state, w_state_nxt;
    logic [FLT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_di, w_di_nxt;
    logic             r_evt, r_lvl, r_ovf;
    logic             w_qual;

    gpi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (CLK_I),
        .i_rst_n (RST_NI),
        .i_d     (DI_I),
        .o_q     (w_sync)
    );

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_di    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_di    <= w_di_nxt;
        end
    end

    // >= rather than == so a length shortened mid-qualify still completes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_di_nxt    = r_di;
        if (EN_I) begin
            if (r_state == STABLE) begin
                if (w_sync != r_di) begin
                    if (FLT_LEN_I == '0) begin
                        w_di_nxt = w_sync;
                    end else begin
                        w_state_nxt = QUALIFY;
                        w_cnt_nxt   = FLT_W'(1);
                    end
                end
            end else if (w_sync == r_di) begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end else if (r_cnt >= FLT_LEN_I) begin
                w_di_nxt    = w_sync;
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end else if (r_cnt != '1) begin
                w_cnt_nxt = r_cnt + FLT_W'(1);
            end
        end
    end

    assign w_qual = (w_di_nxt != r_di) &&
                    ((EDGE_SEL_I & (w_di_nxt ? EDGE_RISE : EDGE_FALL)) != EDGE_NONE);

    // a same-cycle ack frees the slot, so the new edge is captured instead of overflowing
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_evt <= 1'b0;
            r_lvl <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_qual && (!r_evt || ACK_I)) begin
            r_evt <= 1'b1;
            r_lvl <= w_di_nxt;
            r_ovf <= 1'b0;
        end else if (w_qual) begin
            r_ovf <= 1'b1;
        end else if (ACK_I) begin
            r_evt <= 1'b0;
            r_ovf <= 1'b0;
        end
    end

    assign DI_O      = r_di;
    assign EVT_O     = r_evt;
    assign EVT_LVL_O = r_lvl;
    assign OVF_O     = r_ovf;
endmodule

// File: tb/tb_gpi_rx_cond.sv
// tb_gpi_rx_cond: table vectors, directed corner sequences and randomized
// traffic checked against a run-length reference model.
module tb_gpi_rx_cond;
    localparam int SYNC_STAGES = 2;
    localparam int FLT_W       = 4;

    typedef struct {
        logic       rst_n;
        logic       di;
        logic       ack;
        logic [3:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n, di, en, ack;
    logic [FLT_W-1:0] flt;
    logic [1:0]       sel;
    logic             di_o, evt, lvl, ovf;
    int               checks = 0;
    int               errors = 0;

    bit q[$];
    bit m_lvl, m_evt, m_elvl, m_ovf;
    int m_run;

    gpi_rx_cond #(.SYNC_STAGES(SYNC_STAGES), .FLT_W(FLT_W)) dut (
        .CLK_I      (clk),
        .RST_NI     (rst_n),
        .DI_I       (di),
        .EN_I       (en),
        .FLT_LEN_I  (flt),
        .EDGE_SEL_I (sel),
        .ACK_I      (ack),
        .DI_O       (di_o),
        .EVT_O      (evt),
        .EVT_LVL_O  (lvl),
        .OVF_O      (ovf)
    );

    always #5 clk = ~clk;

    // the filtered level flips once the synchronized sample has disagreed
    // with it on flt+1 consecutive enabled cycles
    task automatic model_step();
        bit s, nl, hit;
        if (!rst_n) begin
            q = {};
            repeat (SYNC_STAGES) q.push_front(1'b0);
            m_lvl = 0; m_run = 0; m_evt = 0; m_elvl = 0; m_ovf = 0;
            return;
        end
        s  = q[$];
        nl = m_lvl;
        if (en) begin
            if (s == m_lvl) m_run = 0;
            else begin
                m_run++;
                if (m_run > int'(flt)) begin
                    nl = s;
                    m_run = 0;
                end
            end
        end
        hit = (nl != m_lvl) && (nl ? sel[0] : sel[1]);
        if (hit && m_evt && !ack) m_ovf = 1;
        else if (hit) begin
            m_evt = 1; m_elvl = nl; m_ovf = 0;
        end else if (ack) begin
            m_evt = 0; m_ovf = 0;
        end
        m_lvl = nl;
        void'(q.pop_back());
        q.push_front(di);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if ({di_o, evt, lvl, ovf} !== exp) begin
            errors++;
            $display("FAIL %s: {di,evt,lvl,ovf} got %b want %b at %0t", name, {di_o, evt, lvl, ovf}, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic r, logic d, logic a, logic [3:0] e);
        vec_t v;
        v.rst_n = r; v.di = d; v.ack = a; v.exp = e;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        rst_n = 0; di = 0; en = 1; ack = 0; flt = 3; sel = 2'b01;
        repeat (SYNC_STAGES) q.push_front(1'b0);
        tbl[0] = mk(0, 0, 0, 4'b0000);
        tbl[1] = mk(1, 1, 0, 4'b0000);
        for (int i = 2; i < 6; i++) tbl[i] = mk(1, 1, 0, 4'b0000);
        tbl[6] = mk(1, 1, 0, 4'b1110);
        tbl[7] = mk(1, 1, 1, 4'b1010);
        for (int i = 8; i < 13; i++) tbl[i] = mk(1, 0, 0, 4'b1010);
        tbl[13] = mk(1, 0, 0, 4'b0010);
        tbl[14] = mk(1, 1, 0, 4'b0010);
        tbl[15] = mk(1, 1, 0, 4'b0010);
        for (int i = 16; i < 20; i++) tbl[i] = mk(1, 0, 0, 4'b0010);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst_n; di = tbl[i].di; ack = tbl[i].ack;
            step();
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end
        ack = 0;

        // two edges without ack -> overflow, then ack clears both
        rst_n = 0; di = 0; flt = 0; sel = 2'b11; step(); step();
        check("reset", 4'b0000);
        rst_n = 1; di = 1; step(); step(); step();
        check("first_edge", 4'b1110);
        di = 0; step(); step(); step();
        check("overflow", 4'b0111);
        ack = 1; step(); ack = 0;
        check("ack_clear", 4'b0010);

        // ack coincident with a new qualifying edge
        di = 1; step(); step(); step();
        check("pre_coinc", 4'b1110);
        di = 0; step(); step();
        check("pre_coinc_hold", 4'b1110);
        ack = 1; step(); ack = 0;
        check("ack_coinc", 4'b0100);

        // reset mid-qualify with cnt=2 while an event is pending
        flt = 3; sel = 2'b01; di = 1;
        repeat (4) step();
        check("mid_qualify", 4'b0100);
        rst_n = 0; di = 0; step();
        check("reset_mid", 4'b0000);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("post_reset[%0d]", i), 4'b0000);
        end

        // release with DI high: first rise counts as an event
        rst_n = 0; step(); rst_n = 1; di = 1;
        repeat (5) step();
        check("rel_high_wait", 4'b0000);
        step();
        check("rel_high_rise", 4'b1110);

        // enable gating with bypass filter
        rst_n = 0; di = 0; step(); rst_n = 1; flt = 0; di = 1;
        step(); step();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("en_hold[%0d]", i), 4'b0000);
        end
        en = 1; step();
        check("en_resume", 4'b1110);
        en = 0; ack = 1; step(); en = 1; ack = 0;
        check("ack_while_dis", 4'b1010);

        // randomized segments against the reference model
        for (int seg = 0; seg < 40; seg++) begin
            rst_n = 0; step(); rst_n = 1;
            flt = FLT_W'($urandom_range(0, 5));
            sel = 2'($urandom_range(0, 3));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 5) == 0) di = ~di;
                en    = ($urandom_range(0, 7) != 0);
                ack   = ($urandom_range(0, 5) == 0);
                rst_n = ($urandom_range(0, 299) != 0);
                step();
                check("random", {m_lvl, m_evt, m_elvl, m_ovf});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
